write_pointer_full: RTL and testbench

//   Write-domain half of the dual-clock FIFO, the counterpart of the read-side pointer/empty logic.
//   - Tracks the binary and Gray write pointers.
//   - Synchronises the read Gray pointer into wclk.
//   - Generates wfull, almost-full, a conservative fill level and write enable/address for the RAM.

---
 rtl/write_pointer_full.sv | 103 ++++++++++
 tb/tb_write_pointer_full.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_pointer_full.sv
// Write-domain pointer, full/almost-full and fill-level logic for a dual-clock FIFO.
// Define WFIFO_OVERFLOW_EN to build the sticky woverflow flag; otherwise it is tied low.
module write_pointer_full #(
  parameter int SIZE         = 4,
  parameter int AFULL_THRESH = 14,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic            winc,
  input  logic [SIZE:0]   rptr,
  output logic            wen,
  output logic [SIZE-1:0] waddr,
  output logic [SIZE:0]   wptr,
  output logic            wfull,
  output logic            walmost_full,
  output logic [SIZE:0]   wcount,
  output logic            woverflow
);

  logic [SIZE:0] wbin_reg;
  logic [SIZE:0] wbin_next;
  logic [SIZE:0] wgray_next;
  logic [SIZE:0] wptr_reg;
  logic [SIZE:0] wcount_reg;
  logic [SIZE:0] wcount_next;
  logic [SIZE:0] wq2_rptr;
  logic [SIZE:0] rbin_s;
  logic [SIZE:0] full_ptr;
  logic          wfull_reg;
  logic          walmost_full_reg;
  logic [SIZE:0] sync_reg [SYNC_STAGES];

  // rptr is only ever sampled by the first synchroniser flop.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= rptr;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign wq2_rptr = sync_reg[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (gi = 0; gi <= SIZE; gi++) begin : g_g2b
      assign rbin_s[gi] = ^(wq2_rptr >> gi);
    end
  endgenerate

  assign wen         = winc & ~wfull_reg;
  assign waddr       = wbin_reg[SIZE-1:0];
  assign wbin_next   = wbin_reg + {{SIZE{1'b0}}, wen};
  assign wgray_next  = (wbin_next >> 1) ^ wbin_next;
  assign wcount_next = wbin_next - rbin_s;
  assign full_ptr    = {~wq2_rptr[SIZE:SIZE-1], wq2_rptr[SIZE-2:0]};

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_reg         <= '0;
      wptr_reg         <= '0;
      wcount_reg       <= '0;
      wfull_reg        <= 1'b0;
      walmost_full_reg <= 1'b0;
    end else begin
      wbin_reg         <= wbin_next;
      wptr_reg         <= wgray_next;
      wcount_reg       <= wcount_next;
      wfull_reg        <= (wgray_next == full_ptr);
      walmost_full_reg <= (wcount_next >= (SIZE+1)'(AFULL_THRESH));
    end
  end

  assign wptr         = wptr_reg;
  assign wcount       = wcount_reg;
  assign wfull        = wfull_reg;
  assign walmost_full = walmost_full_reg;

`ifdef WFIFO_OVERFLOW_EN
  logic woverflow_reg;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow_reg <= 1'b0;
    end else begin
      woverflow_reg <= woverflow_reg | (winc & wfull_reg);
    end
  end

  assign woverflow = woverflow_reg;
`else
  assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_full.sv
// Directed bench for write_pointer_full (SIZE=4, AFULL_THRESH=14, SYNC_STAGES=2).
module tb_write_pointer_full;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  int checks = 0;
  int fails  = 0;

`ifdef WFIFO_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  write_pointer_full #(.SIZE(4), .AFULL_THRESH(14), .SYNC_STAGES(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset;
    @(negedge wclk);
    winc = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    checks++; if (wptr !== 5'b00010) begin fails++; $display("FAIL reset_pre_wptr: got %b expected %b", wptr, 5'b00010); end
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    checks++; if (wptr !== 5'd0) begin fails++; $display("FAIL reset_wptr: got %b expected 0", wptr); end
    checks++; if (waddr !== 4'd0) begin fails++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
    checks++; if (wcount !== 5'd0) begin fails++; $display("FAIL reset_wcount: got %0d expected 0", wcount); end
    checks++; if ({wfull, walmost_full, woverflow} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {wfull, walmost_full, woverflow}); end
    checks++; if (wen !== 1'b1) begin fails++; $display("FAIL reset_wen_hi: got %b expected 1", wen); end
    winc = 1'b0;
    #1;
    checks++; if (wen !== 1'b0) begin fails++; $display("FAIL reset_wen_lo: got %b expected 0", wen); end
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      @(negedge wclk);
      winc = 1'b1;
      #1;
      checks++; if (wen !== 1'b1) begin fails++; $display("FAIL fill_wen[%0d]: got %b expected 1", i, wen); end
      checks++; if (waddr !== 4'(i)) begin fails++; $display("FAIL fill_waddr[%0d]: got %0d expected %0d", i, waddr, i); end
      @(posedge wclk);
      #1;
      if (i == 12) begin
        checks++; if (walmost_full !== 1'b0) begin fails++; $display("FAIL fill_afull_13: got %b expected 0", walmost_full); end
      end
      if (i == 13) begin
        checks++; if (walmost_full !== 1'b1) begin fails++; $display("FAIL fill_afull_14: got %b expected 1", walmost_full); end
      end
      if (i == 14) begin
        checks++; if (wfull !== 1'b0) begin fails++; $display("FAIL fill_full_15: got %b expected 0", wfull); end
      end
    end
    checks++; if (wfull !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", wfull); end
    checks++; if (wcount !== 5'd16) begin fails++; $display("FAIL fill_wcount: got %0d expected 16", wcount); end
    checks++; if (wptr !== 5'b11000) begin fails++; $display("FAIL fill_wptr: got %b expected 11000", wptr); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      winc = 1'b1;
      #1;
      checks++; if (wen !== 1'b0) begin fails++; $display("FAIL ovf_wen[%0d]: got %b expected 0", i, wen); end
      checks++; if (waddr !== 4'd0) begin fails++; $display("FAIL ovf_waddr[%0d]: got %0d expected 0", i, waddr); end
      @(posedge wclk);
      #1;
      checks++; if (wptr !== 5'b11000) begin fails++; $display("FAIL ovf_wptr[%0d]: got %b expected 11000", i, wptr); end
      checks++; if (wfull !== 1'b1) begin fails++; $display("FAIL ovf_full[%0d]: got %b expected 1", i, wfull); end
      checks++; if (woverflow !== EXP_OVF) begin fails++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, woverflow, EXP_OVF); end
    end
    @(negedge wclk);
    winc = 1'b0;
  endtask

  task automatic test_drain;
    @(negedge wclk);
    rptr = 5'b00110;
    for (int e = 1; e <= 3; e++) begin
      @(posedge wclk);
      #1;
      if (e < 3) begin
        checks++; if (wfull !== 1'b1) begin fails++; $display("FAIL drain_full_early[%0d]: got %b expected 1", e, wfull); end
        checks++; if (wcount !== 5'd16) begin fails++; $display("FAIL drain_wcount_early[%0d]: got %0d expected 16", e, wcount); end
      end else begin
        checks++; if (wfull !== 1'b0) begin fails++; $display("FAIL drain_full: got %b expected 0", wfull); end
        checks++; if (wcount !== 5'd12) begin fails++; $display("FAIL drain_wcount: got %0d expected 12", wcount); end
        checks++; if (walmost_full !== 1'b0) begin fails++; $display("FAIL drain_afull: got %b expected 0", walmost_full); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge wclk);
      winc = 1'b1;
      @(posedge wclk);
      #1;
      if (i == 1) begin
        checks++; if (walmost_full !== 1'b1) begin fails++; $display("FAIL refill_afull: got %b expected 1", walmost_full); end
      end
      if (i == 2) begin
        checks++; if (wfull !== 1'b0) begin fails++; $display("FAIL refill_full_early: got %b expected 0", wfull); end
      end
    end
    checks++; if (wfull !== 1'b1) begin fails++; $display("FAIL refill_full: got %b expected 1", wfull); end
    checks++; if (wcount !== 5'd16) begin fails++; $display("FAIL refill_wcount: got %0d expected 16", wcount); end
    @(negedge wclk);
    winc = 1'b0;
  endtask

  task automatic test_wrap;
    int n;
    @(negedge wclk);
    rptr   = 5'd0;
    wrst_n = 1'b0;
    #1;
    wrst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge wclk);
      winc = 1'b1;
      rptr = (n >= 5) ? gray(5'(n - 5)) : 5'd0;
      #1;
      checks++; if (wen !== 1'b1) begin fails++; $display("FAIL wrap_wen[%0d]: got %b expected 1", n, wen); end
      checks++; if (waddr !== 4'(n % 16)) begin fails++; $display("FAIL wrap_waddr[%0d]: got %0d expected %0d", n, waddr, n % 16); end
      @(posedge wclk);
      #1;
      n++;
      checks++; if (wptr !== gray(5'(n % 32))) begin fails++; $display("FAIL wrap_wptr[%0d]: got %b expected %b", n, wptr, gray(5'(n % 32))); end
      checks++; if (wfull !== 1'b0) begin fails++; $display("FAIL wrap_full[%0d]: got %b expected 0", n, wfull); end
      if (n >= 8) begin
        checks++; if (wcount !== 5'd8 && wcount !== 5'd9) begin fails++; $display("FAIL wrap_wcount[%0d]: got %0d expected 8 or 9", n, wcount); end
      end
      if (n == 31) begin
        checks++; if (wptr !== 5'b10000) begin fails++; $display("FAIL wrap_top: got %b expected 10000", wptr); end
      end
      if (n == 32) begin
        checks++; if (wptr !== 5'b00000) begin fails++; $display("FAIL wrap_zero: got %b expected 00000", wptr); end
      end
    end
    @(negedge wclk);
    winc = 1'b0;
  endtask

  task automatic test_mid_reset;
    @(negedge wclk);
    rptr   = 5'd0;
    wrst_n = 1'b0;
    #1;
    wrst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge wclk);
      winc = 1'b1;
      @(posedge wclk);
    end
    #1;
    checks++; if (wcount !== 5'd9) begin fails++; $display("FAIL mid_pre_wcount: got %0d expected 9", wcount); end
    checks++; if (wfull !== 1'b0) begin fails++; $display("FAIL mid_pre_full: got %b expected 0", wfull); end
    @(negedge wclk);
    winc   = 1'b0;
    wrst_n = 1'b0;
    #1;
    checks++; if (wcount !== 5'd0) begin fails++; $display("FAIL mid_wcount: got %0d expected 0", wcount); end
    checks++; if (wptr !== 5'd0) begin fails++; $display("FAIL mid_wptr: got %b expected 0", wptr); end
    checks++; if (waddr !== 4'd0) begin fails++; $display("FAIL mid_waddr: got %0d expected 0", waddr); end
    checks++; if ({wfull, walmost_full, woverflow} !== 3'b000) begin fails++; $display("FAIL mid_flags: got %b expected 000", {wfull, walmost_full, woverflow}); end
    #2;
    wrst_n = 1'b1;
    @(negedge wclk);
    winc = 1'b1;
    #1;
    checks++; if (waddr !== 4'd0) begin fails++; $display("FAIL mid_next_waddr: got %0d expected 0", waddr); end
    checks++; if (wen !== 1'b1) begin fails++; $display("FAIL mid_next_wen: got %b expected 1", wen); end
    @(posedge wclk);
    #1;
    checks++; if (wptr !== 5'b00001) begin fails++; $display("FAIL mid_next_wptr: got %b expected 00001", wptr); end
    checks++; if (wcount !== 5'd1) begin fails++; $display("FAIL mid_next_wcount: got %0d expected 1", wcount); end
    @(negedge wclk);
    winc = 1'b0;
  endtask

  initial begin
    wrst_n = 1'b0;
    winc   = 1'b0;
    rptr   = 5'd0;
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
